// File: rtl/dap_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dap_sram_pkg
// Description : Shared types and constants for the DAP-side SRAM controller
//               (FSM state encoding, wait-counter width, out-of-range data).
// Revision    : 1.0 - initial release
// ============================================================================
package dap_sram_pkg;

  // Controller states; 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    WHOLD = 3'd3,
    ACK   = 3'd4,
    REARM = 3'd5
  } state_e;

  // Wait-state counter width; RD_WAIT / WR_WAIT must fit in it.
  localparam int WAIT_W = 4;

  // Data returned for a read that falls outside the SRAM address range.
  localparam logic [15:0] OOR_RD_DATA = 16'hFFFF;

endpackage : dap_sram_pkg
`default_nettype wire

// File: rtl/dap_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dap_sram_ctrl
// Description : Executes one access per DAP bridge request on an external
//               asynchronous 16-bit SRAM with parameterised wait states.
//               Optional macro DAP_SRAM_RANGE_CHECK_EN adds rejection of
//               addresses above the SRAM range and a sticky range_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module dap_sram_ctrl
  import dap_sram_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       addr,
  input  logic [15:0]       d_wr,
  output logic [15:0]       d_rd,
  input  logic              w_rq,
  input  logic              r_rq,
  output logic              rq_ack,
`ifdef DAP_SRAM_RANGE_CHECK_EN
  output logic              range_err,
`endif
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [WAIT_W-1:0] RD_LAST = RD_WAIT[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WR_LAST = WR_WAIT[WAIT_W-1:0];

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         d_rd_q, d_rd_d;
  logic                addr_oor;
  logic                drive_bus;

`ifdef DAP_SRAM_RANGE_CHECK_EN
  logic                range_err_q, range_err_d;

  // Any set bit above the SRAM word-address range marks the request invalid.
  assign addr_oor = (addr >> ADDR_W) != 24'd0;

  // Sticky range error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  // Flag is raised when IDLE rejects an out-of-range request.
  always_comb begin
    range_err_d = range_err_q;
    if (state_q == IDLE && (r_rq || w_rq) && addr_oor) range_err_d = 1'b1;
  end

  assign range_err = range_err_q;
`else
  logic unused_addr_hi;

  // Upper address bits alias onto the SRAM range in this build.
  assign addr_oor       = 1'b0;
  assign unused_addr_hi = ^(addr >> ADDR_W);
`endif

  // State, counter and datapath registers; reset releases the bus at once
  // because every strobe is decoded from the asynchronously reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      sram_a_q <= '0;
      wdata_q  <= '0;
      d_rd_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      sram_a_q <= sram_a_d;
      wdata_q  <= wdata_d;
      d_rd_q   <= d_rd_d;
    end
  end

  // Next-state logic: request acceptance, wait counting and read capture.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    sram_a_d = sram_a_q;
    wdata_d  = wdata_q;
    d_rd_d   = d_rd_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (r_rq || w_rq) begin
          if (addr_oor) begin
            // Rejected request: no SRAM cycle, straight to the ack.
            state_d = ACK;
            if (r_rq) d_rd_d = OOR_RD_DATA;
          end else begin
            sram_a_d = addr[ADDR_W-1:0];
            if (r_rq) begin
              state_d = RD;
            end else begin
              wdata_d = d_wr;
              state_d = WR;
            end
          end
        end
      end
      RD: begin
        if (wait_q == RD_LAST) begin
          d_rd_d  = sram_dq;
          wait_d  = '0;
          state_d = ACK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WR: begin
        if (wait_q == WR_LAST) begin
          wait_d  = '0;
          state_d = WHOLD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WHOLD:   state_d = ACK;
      ACK:     state_d = REARM;
      REARM:   if (!r_rq && !w_rq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and bus enable decoded from the registered state.
  assign sram_ce_n = !(state_q == RD || state_q == WR || state_q == WHOLD);
  assign sram_oe_n = (state_q != RD);
  assign sram_we_n = (state_q != WR);
  assign drive_bus = (state_q == WR || state_q == WHOLD);
  assign sram_dq   = drive_bus ? wdata_q : 16'hzzzz;

  assign rq_ack = (state_q == ACK);
  assign d_rd   = d_rd_q;
  assign sram_a = sram_a_q;

endmodule : dap_sram_ctrl
`default_nettype wire

// File: tb/tb_dap_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dap_sram_ctrl
// Description : Self-checking bench for dap_sram_ctrl with a small SRAM model
//               and an expectation queue filled when requests are issued.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dap_sram_ctrl;

  localparam int ADDR_W  = 19;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  typedef struct {
    bit          rd;
    logic [23:0] a;
    logic [15:0] data;
    int          lat;
    int          oe;
    int          we;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [23:0]       addr;
  logic [15:0]       d_wr;
  wire  [15:0]       d_rd;
  logic              w_rq;
  logic              r_rq;
  wire               rq_ack;
  wire  [ADDR_W-1:0] sram_a;
  wire  [15:0]       sram_dq;
  wire               sram_ce_n;
  wire               sram_oe_n;
  wire               sram_we_n;
`ifdef DAP_SRAM_RANGE_CHECK_EN
  wire               range_err;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  int   oe_cyc = 0;
  int   we_cyc = 0;
  int   contention = 0;
  bit   prev_whold = 1'b0;
  logic [15:0] whold_dq = '0;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  dap_sram_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .d_wr     (d_wr),
    .d_rd     (d_rd),
    .w_rq     (w_rq),
    .r_rq     (r_rq),
    .rq_ack   (rq_ack),
`ifdef DAP_SRAM_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .sram_a   (sram_a),
    .sram_dq  (sram_dq),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // SRAM model: drives the bus only while read-enabled.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a[9:0]] : 16'hzzzz;

  // SRAM storage: preloaded under reset, written while WE_n is low.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h123] <= 16'hBEEF;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_a[9:0]] <= sram_dq;
    end
  end

  // Strobe-cycle counters and bus-turnaround monitor.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_oe_n) oe_cyc <= oe_cyc + 1;
    if (!sram_ce_n && !sram_we_n) we_cyc <= we_cyc + 1;
    if (!sram_oe_n && (!sram_we_n || prev_whold)) contention <= contention + 1;
    prev_whold <= !sram_ce_n && sram_oe_n && sram_we_n;
    if (!sram_ce_n && sram_oe_n && sram_we_n) whold_dq <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (caller sits just after a falling edge), wait for the
  // ack, optionally hold the request afterwards, then score the result.
  task automatic access(input bit rd, input logic [23:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_data, input int lat, input int nacc,
                        input int hold);
    int   n;
    int   oe0;
    int   we0;
    int   extra;
    exp_t e;
    exp_q.push_back('{rd, a, exp_data, lat,
                      rd ? nacc * (RD_WAIT + 1) : 0,
                      rd ? 0 : nacc * (WR_WAIT + 1)});
    oe0  = oe_cyc;
    we0  = we_cyc;
    addr = a;
    d_wr = wd;
    r_rq = rd;
    w_rq = !rd;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rq_ack && n < 40);
    e = exp_q.pop_front();
    check(rd ? "rd_latency" : "wr_latency", n, e.lat);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rq_ack) extra++;
    end
    if (hold > 0) check("held_rq_extra_ack", extra, 0);
    r_rq = 1'b0;
    w_rq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (e.rd) check("rd_data", d_rd, e.data);
    else      check("wr_mem", mem[e.a[9:0]], e.data);
    check(rd ? "rd_oe_cycles" : "wr_oe_cycles", oe_cyc - oe0, e.oe);
    check(rd ? "rd_we_cycles" : "wr_we_cycles", we_cyc - we0, e.we);
    if (nacc > 0) check("sram_a", sram_a, e.a[ADDR_W-1:0]);
  endtask

  initial begin
    rst  = 1'b1;
    addr = '0;
    d_wr = '0;
    r_rq = 1'b0;
    w_rq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",  rq_ack, 0);
    check("rst_d_rd", d_rd, 0);
    check("rst_a",    sram_a, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
`ifdef DAP_SRAM_RANGE_CHECK_EN
    check("rst_range_err", range_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic read and write.
    access(1'b1, 24'h000123, 16'h0000, 16'hBEEF, RD_WAIT + 2, 1, 0);
    access(1'b0, 24'h000010, 16'h55AA, 16'h55AA, WR_WAIT + 3, 1, 0);
    check("whold_dq", whold_dq, 16'h55AA);
    check("d_rd_after_wr", d_rd, 16'hBEEF);

    // Request held well past the ack: exactly one access.
    access(1'b1, 24'h000010, 16'h0000, 16'h55AA, RD_WAIT + 2, 1, 3);

    // Write then read at the same address back to back.
    access(1'b0, 24'h000055, 16'h1234, 16'h1234, WR_WAIT + 3, 1, 0);
    access(1'b1, 24'h000055, 16'h0000, 16'h1234, RD_WAIT + 2, 1, 0);
    check("bus_contention", contention, 0);

`ifdef DAP_SRAM_RANGE_CHECK_EN
    // Out-of-range read: no strobe, immediate ack, error value.
    access(1'b1, 24'h800000, 16'h0000, 16'hFFFF, 1, 0, 0);
    check("range_err_set", range_err, 1);
`else
    // Upper bits alias onto the SRAM range.
    access(1'b1, 24'h800123, 16'h0000, 16'hBEEF, RD_WAIT + 2, 1, 0);
`endif

    // Reset asserted mid-read releases strobes without a clock edge.
    addr = 24'h000123;
    r_rq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_phase_oe_n", sram_oe_n, 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ce_n", sram_ce_n, 1);
    check("async_rst_oe_n", sram_oe_n, 1);
    check("async_rst_we_n", sram_we_n, 1);
    check("async_rst_ack",  rq_ack, 0);
    r_rq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_d_rd", d_rd, 0);
    check("post_rst_a",    sram_a, 0);
    @(negedge clk);
    access(1'b1, 24'h000123, 16'h0000, 16'hBEEF, RD_WAIT + 2, 1, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule : tb_dap_sram_ctrl
`default_nettype wire

// File: doc/dap_sram_ctrl.md
Name: dap_sram_ctrl

Overview:
- Memory-side stage directly downstream of the AVR DAP bridge.
- Consumes the bridge's 24-bit word address, 16-bit write data and level-held r_rq/w_rq requests.
- Executes one access per request on an external asynchronous 16-bit SRAM, returns read data on d_rd, and pulses rq_ack.
- Wait states are parameterised so the same block serves slow and fast SRAM parts.

Parameters:
- ADDR_W, 19, SRAM word-address width; uses addr[ADDR_W-1:0].
- RD_WAIT, 2, extra cycles the OE_n/CE_n low phase is held before read data is sampled (0..15).
- WR_WAIT, 2, extra cycles WE_n is held low (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- addr  in  24  word address from DAP bridge
- d_wr  in  16  write data from DAP bridge
- d_rd  out  16  registered read data to DAP bridge
- w_rq  in  1  write request, level, held until rq_ack
- r_rq  in  1  read request, level, held until rq_ack
- rq_ack  out  1  one-cycle completion pulse
- sram_a  out  ADDR_W  SRAM word address (registered)
- sram_dq  inout  16  SRAM data bus
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- Reset state:
  - State is IDLE; rq_ack=0; d_rd=0; sram_a=0.
  - sram_ce_n, sram_oe_n and sram_we_n are 1; sram_dq is Z.
  - Assertion of rst mid-access releases all strobes and the bus immediately, without waiting for a clock edge.
- States and transitions:
  - IDLE: if r_rq=1, latch sram_a<=addr[ADDR_W-1:0] and go to RD. Else if w_rq=1, latch sram_a and the internal write-data register <= d_wr, then go to WR. If both requests are high, read wins.
  - RD: ce_n=0, oe_n=0 for RD_WAIT+1 cycles, counted by a 4-bit wait counter. On the last cycle, d_rd<=sram_dq. Then go to ACK.
  - WR: ce_n=0, we_n=0, dq driven for WR_WAIT+1 cycles. Then go to WHOLD.
  - WHOLD: we_n=1, ce_n=0, dq still driven for 1 cycle (data hold). Then go to ACK.
  - ACK: all strobes are inactive and dq is Z; rq_ack=1 for exactly this cycle. Go to REARM.
  - REARM: wait until r_rq=0 and w_rq=0, then go to IDLE. This prevents a request still held high from being executed twice; the bridge drops its request one cycle after the ack.
- Latency, counted from the cycle IDLE samples the request:
  - Read: rq_ack is high RD_WAIT+2 cycles later (4 at default).
  - Write: rq_ack is high WR_WAIT+3 cycles later (5 at default).
- Bus ownership:
  - sram_dq is driven only in WR and WHOLD.
  - ACK gives at least one Z cycle before the next RD starts, so a write followed by a read has no bus contention.
- d_rd holds its value until the next read completes; writes never change it.
- A request that drops before rq_ack is still completed; the ack is pulsed regardless.
- addr[23:ADDR_W] is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: DAP_SRAM_RANGE_CHECK_EN
- With the macro defined:
  - A request with addr[23:ADDR_W] != 0 goes from IDLE straight to ACK, and no SRAM strobe is asserted.
  - A read in this case sets d_rd=16'hFFFF; a write is dropped.
  - Extra output port range_err (1 bit, reset 0) is set sticky and cleared only by rst.
- Without the macro: there is no range_err port, and the upper address bits are ignored (the address aliases).

Decomposition:
- Package dap_sram_pkg holds:
  - the state enum (IDLE, RD, WR, WHOLD, ACK, REARM), 3 bits;
  - the wait-counter width constant (4);
  - the out-of-range read value 16'hFFFF.
- No sub-module. The FSM, counter and tri-state driver sit in one module; the design is roughly 150-200 lines.

Test Plan:
- Reset, then a read of addr=24'h000123 with the SRAM model returning 16'hBEEF: sram_a=0x123, oe_n low 3 cycles, rq_ack at cycle 4, d_rd=16'hBEEF.
- A write of addr=24'h000010, d_wr=16'h55AA: we_n low 3 cycles, dq=16'h55AA through WHOLD, rq_ack at cycle 5, model holds 16'h55AA at 0x10.
- r_rq held high for 3 cycles after rq_ack: exactly one SRAM access, and the FSM stays in REARM until r_rq=0.
- Back-to-back write then read at the same address: no cycle with dq driven while oe_n=0, and the read returns the written value.
- Assert rst during the RD phase: strobes go high and dq goes Z within the same cycle (asynchronously); after release, the FSM is in IDLE and d_rd=0.
- With DAP_SRAM_RANGE_CHECK_EN, read of addr=24'h800000: no strobe, rq_ack one cycle later, d_rd=16'hFFFF, range_err=1.
